// File: rtl/nds_sync_rx_fifo.sv
// rtl/nds_sync_rx_fifo.sv - receive-side circular FIFO behind the pulse-plus-data synchronizer
//
// Purpose:
//   Buffers each synchronized strobe (in_pulse) and its word (in_data) in a
//   small circular FIFO in the b_clk domain. A consumer drains words through
//   a valid/ready handshake. Pushes that arrive while the FIFO is full and no
//   pop frees a slot are dropped, and a sticky overflow flag records the drop.
//
// Ports:
//   b_clk      in   clock, rising edge
//   b_reset_n  in   asynchronous active-low reset
//   clear      in   synchronous flush of pointers and overflow (highest priority)
//   in_pulse   in   push strobe, one cycle per word
//   in_data    in   word to push (DATA_BIT)
//   out_valid  out  head entry available
//   out_ready  in   consumer accepts the head when out_valid=1
//   out_data   out  head entry (DATA_BIT)
//   count      out  stored entries, 0..DEPTH (ADDR_BIT+1)
//   full       out  count == DEPTH
//   overflow   out  sticky dropped-word flag
//
// Configuration:
//   NDS_SYNC_RX_FIFO_BYPASS_EN - when defined, an empty FIFO forwards in_data
//   to out_data combinationally; if out_ready is also high the word is
//   consumed without being stored. When undefined, latency is exactly 1 cycle.

module nds_sync_rx_fifo #(
  parameter int                  DATA_BIT         = 32,
  parameter int                  ADDR_BIT         = 2,
  parameter logic [DATA_BIT-1:0] RESET_DATA_VALUE = {DATA_BIT{1'b0}}
) (
  input  logic                b_clk,
  input  logic                b_reset_n,
  input  logic                clear,
  input  logic                in_pulse,
  input  logic [DATA_BIT-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_BIT-1:0] out_data,
  output logic [ADDR_BIT:0]   count,
  output logic                full,
  output logic                overflow
);

  localparam int DEPTH = 1 << ADDR_BIT;

  logic [DATA_BIT-1:0] r_mem [DEPTH];
  logic [ADDR_BIT:0]   r_wp;
  logic [ADDR_BIT:0]   r_rp;
  logic                r_overflow;

  logic w_empty;
  logic w_full;
  logic w_fifo_pop;
  logic w_bypass;
  logic w_push;
  logic w_drop;

  // The extra pointer MSB separates full (same slot, different lap) from empty.
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[ADDR_BIT-1:0] == r_rp[ADDR_BIT-1:0]) &&
                   (r_wp[ADDR_BIT] != r_rp[ADDR_BIT]);

  // A pop only ever takes a stored entry; a bypassed word never touches rp.
  assign w_fifo_pop = !w_empty && out_ready;

`ifdef NDS_SYNC_RX_FIFO_BYPASS_EN
  assign w_bypass  = w_empty && in_pulse && out_ready && !clear;
  assign out_valid = !w_empty || (in_pulse && !clear);
  assign out_data  = (w_empty && in_pulse && !clear) ? in_data
                                                     : r_mem[r_rp[ADDR_BIT-1:0]];
`else
  assign w_bypass  = 1'b0;
  assign out_valid = !w_empty;
  assign out_data  = r_mem[r_rp[ADDR_BIT-1:0]];
`endif

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = in_pulse && (!w_full || w_fifo_pop) && !w_bypass;
  assign w_drop = in_pulse && w_full && !w_fifo_pop;

  always_ff @(posedge b_clk or negedge b_reset_n) begin
    if (!b_reset_n) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= RESET_DATA_VALUE;
      end
    end else if (clear) begin
      // Memory is left as is; only the pointers define what is stored.
      r_wp       <= '0;
      r_rp       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp[ADDR_BIT-1:0]] <= in_data;
        r_wp                      <= r_wp + 1'b1;
      end
      if (w_fifo_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign count    = r_wp - r_rp;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_nds_sync_rx_fifo.sv
// tb/tb_nds_sync_rx_fifo.sv - scoreboard bench for nds_sync_rx_fifo

module tb_nds_sync_rx_fifo;

  logic        b_clk     = 1'b0;
  logic        b_reset_n = 1'b0;
  logic        clear     = 1'b0;
  logic        in_pulse  = 1'b0;
  logic [31:0] in_data   = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  count;
  logic        full;
  logic        overflow;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];

  always #5 b_clk = ~b_clk;

  nds_sync_rx_fifo #(
    .DATA_BIT(32),
    .ADDR_BIT(2),
    .RESET_DATA_VALUE(32'h0)
  ) dut (
    .b_clk    (b_clk),
    .b_reset_n(b_reset_n),
    .clear    (clear),
    .in_pulse (in_pulse),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .full     (full),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted handshake must deliver the oldest expected word.
  always @(negedge b_clk) begin
    if (b_reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%08h expected none", out_data);
      end else begin
        check("scoreboard_word", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge b_clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input bit keep);
    in_pulse = 1'b1;
    in_data  = d;
    if (keep) exp_q.push_back(d);
    tick();
    in_pulse = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard     = 0;
    out_ready = 1'b1;
    while (out_valid && guard < 20) begin
      tick();
      guard++;
    end
    out_ready = 1'b0;
    check({name, "_valid_low"}, {31'b0, out_valid}, 32'd0);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge b_clk);
    #1;
    // Reset state
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_data", out_data, 32'h0);
    b_reset_n = 1'b1;
    tick();

    // Single push, 1-cycle latency
    push_word(32'hA5A5_0001, 1);
    check("p1_valid", {31'b0, out_valid}, 32'd1);
    check("p1_data", out_data, 32'hA5A5_0001);
    check("p1_count", 32'(count), 32'd1);
    check("p1_full", {31'b0, full}, 32'd0);
    drain("p1");

    // Fill then overflow
    for (int i = 0; i < 4; i++) push_word(32'h10 + i, 1);
    push_word(32'h14, 0);
    check("ovf_full", {31'b0, full}, 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", {31'b0, overflow}, 32'd1);
    check("ovf_head", out_data, 32'h10);
    drain("ovf");
    check("ovf_sticky", {31'b0, overflow}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_overflow", {31'b0, overflow}, 32'd0);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) push_word(32'h10 + i, 1);
    in_pulse  = 1'b1;
    in_data   = 32'h20;
    out_ready = 1'b1;
    exp_q.push_back(32'h20);
    tick();
    in_pulse  = 1'b0;
    out_ready = 1'b0;
    check("pp_count", 32'(count), 32'd4);
    check("pp_full", {31'b0, full}, 32'd1);
    check("pp_overflow", {31'b0, overflow}, 32'd0);
    check("pp_head", out_data, 32'h11);
    drain("pp");

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pulse = 1'b1;
      in_data  = 32'h100 + i;
      exp_q.push_back(32'h100 + i);
      tick();
      check("stream_count_le1", {31'b0, (count <= 3'd1)}, 32'd1);
    end
    in_pulse = 1'b0;
    drain("stream");

    // Clear beats a simultaneous push
    for (int i = 0; i < 4; i++) push_word(32'h30 + i, 1);
    push_word(32'h34, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("c3_count", 32'(count), 32'd3);
    check("c3_overflow", {31'b0, overflow}, 32'd1);
    clear    = 1'b1;
    in_pulse = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    exp_q.delete();
    tick();
    clear    = 1'b0;
    in_pulse = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_valid", {31'b0, out_valid}, 32'd0);
    check("clr_overflow2", {31'b0, overflow}, 32'd0);
    push_word(32'h40, 1);
    check("clr_next_head", out_data, 32'h40);
    check("clr_next_count", 32'(count), 32'd1);
    drain("clr");

    // Asynchronous reset mid-operation
    push_word(32'h50, 1);
    push_word(32'h51, 1);
    #2;
    b_reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_data", out_data, 32'h0);
    tick();
    b_reset_n = 1'b1;
    push_word(32'h52, 1);
    check("arst_next_count", 32'(count), 32'd1);
    check("arst_next_head", out_data, 32'h52);
    drain("arst");

`ifdef NDS_SYNC_RX_FIFO_BYPASS_EN
    // Same-cycle bypass on an empty FIFO
    in_pulse  = 1'b1;
    in_data   = 32'h55;
    out_ready = 1'b1;
    exp_q.push_back(32'h55);
    #1;
    check("byp_valid", {31'b0, out_valid}, 32'd1);
    check("byp_data", out_data, 32'h55);
    tick();
    in_pulse  = 1'b0;
    out_ready = 1'b0;
    check("byp_count", 32'(count), 32'd0);
    check("byp_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nds_sync_rx_fifo.md
# nds_sync_rx_fifo

Receive-side buffer that sits directly downstream of the pulse-plus-data clock-domain synchronizer, entirely in the b_clk domain. Each synchronized strobe (in_pulse) with its captured word (in_data) is pushed into a small circular FIFO. Words are drained by a consumer with a valid/ready handshake. A sticky flag records any word dropped while the FIFO is full, so back-to-back transfers from the source domain are not silently lost.

## Interface
Parameters:
- DATA_BIT, 32, width of each stored word.
- ADDR_BIT, 2, pointer width; DEPTH = 2**ADDR_BIT entries; legal values 1..6.
- RESET_DATA_VALUE, {DATA_BIT{1'b0}}, reset contents of every entry and of out_data.

Ports:
- b_clk  input  1  clock; all logic on the rising edge.
- b_reset_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous flush; empties the FIFO and clears overflow.
- in_pulse  input  1  push strobe, one b_clk cycle per word.
- in_data  input  DATA_BIT  word to push; sampled only when in_pulse=1.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts the head when out_valid=1.
- out_data  output  DATA_BIT  head entry; stable while out_valid=1 and out_ready=0.
- count  output  ADDR_BIT+1  number of stored entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set when a push is dropped.

## Operation
- Storage: DEPTH x DATA_BIT register array, write pointer wp and read pointer rp, each ADDR_BIT+1 bits. The extra MSB distinguishes full from empty.
  - count = wp - rp, modulo 2**(ADDR_BIT+1).
  - Empty when wp == rp.
  - Full when the low ADDR_BIT bits are equal and the MSBs differ.
- Push: in_pulse=1 and (not full, or a pop in the same cycle).
  - Writes mem[wp[ADDR_BIT-1:0]] <= in_data.
  - wp increments and wraps naturally at 2**(ADDR_BIT+1).
- Pop: out_valid=1 and out_ready=1; rp increments.
  - out_ready while out_valid=0 has no effect.
- Simultaneous push and pop: both happen and count is unchanged. When full, this frees the slot being read, so no overflow.
- Push while full without a pop:
  - The word is dropped and the stored contents are unchanged.
  - overflow <= 1; it stays 1 until clear or reset.
- clear=1 has priority over everything else in that cycle:
  - wp <= 0, rp <= 0, overflow <= 0.
  - Memory contents are not required to change.
  - A push or pop in the same cycle is ignored and does not set overflow.
- out_data = mem[rp[ADDR_BIT-1:0]], a combinational read of the register array.
- Reset values: wp=0, rp=0, every entry = RESET_DATA_VALUE, overflow=0. Hence out_valid=0, count=0, full=0, out_data=RESET_DATA_VALUE.

## Timing
- Push-to-valid latency: 1 cycle. A word pushed at edge N appears on out_valid/out_data after edge N.
- count and full update on the edge following the push or pop.
- overflow rises on the edge that drops the word.
- Throughput: one push and one pop per cycle sustained, at any occupancy.
- Reset asserted mid-operation: all state returns to reset values asynchronously and stored words are discarded. The first push after b_reset_n deasserts is accepted normally.

## Configuration
- NDS_SYNC_RX_FIFO_BYPASS_EN defined: the FIFO gains a same-cycle bypass.
  - Condition: FIFO empty, in_pulse=1, out_ready=1, clear=0.
  - Response: out_valid=1 and out_data=in_data combinationally in that cycle. The word is consumed without being written, and wp/rp do not move.
  - If the FIFO is empty, in_pulse=1 and out_ready=0, out_valid shows the word combinationally and it is also stored normally.
- Macro undefined: no combinational path from in_pulse/in_data to the outputs. Latency is exactly 1 cycle.

## Test plan
All scenarios use DEPTH=4, DATA_BIT=32, macro undefined unless stated.
- Reset, then push 0xA5A5_0001 with out_ready=0 -> next cycle: out_valid=1, out_data=0xA5A5_0001, count=1, full=0.
- Push 4 words 0x10..0x13, then push 0x14 with out_ready=0 -> full=1, count=4, overflow=1. Draining yields 0x10, 0x11, 0x12, 0x13, then out_valid=0.
- FIFO full, push 0x20 with out_ready=1 in the same cycle -> pops head 0x10, stores 0x20, count stays 4, overflow stays 0. 0x20 emerges fourth.
- Stream 10 words with in_pulse and out_ready held at 1 every cycle -> all 10 received in order, pointers wrap, count never exceeds 1.
- 3 words stored with overflow=1; assert clear together with in_pulse -> next cycle: count=0, out_valid=0, overflow=0, pushed word absent.
- NDS_SYNC_RX_FIFO_BYPASS_EN defined, FIFO empty, in_pulse=1 with 0x55, out_ready=1 -> same cycle: out_valid=1, out_data=0x55; next cycle: count=0.
